// File: rtl/power_table_collector_if.sv
// Bus bundle for power_table_collector: start, frame input, table read port and result outputs.
// master drives start/frame_vld/frame_in/rd_addr; slave (the collector) drives everything else.
interface power_table_collector_if;
  logic        start;
  logic        frame_vld;
  logic [31:0] frame_in;
  logic [3:0]  rd_addr;
  logic [3:0]  rd_data;
  logic        ack_vld;
  logic [31:0] ack_data;
  logic [3:0]  chip_count;
  logic [7:0]  err_cnt;
  logic        done;
  logic        fail;
  logic [15:0] sat_mask;

  modport master (
    output start, frame_vld, frame_in, rd_addr,
    input  rd_data, ack_vld, ack_data, chip_count,
    input  err_cnt, done, fail, sat_mask
  );

  modport slave (
    input  start, frame_vld, frame_in, rd_addr,
    output rd_data, ack_vld, ack_data, chip_count,
    output err_cnt, done, fail, sat_mask
  );
endinterface

// File: rtl/power_table_collector.sv
// Collects per-chip p_state frames into a 16-entry table, acking each accepted frame.
// Ports: clk, rst (sync, active-high), bus (slave modport). Optional macro PWR_SAT_FLAG_EN
// enables sat_mask tracking of chips that reported p_state 4'hF; otherwise sat_mask is 0.
module power_table_collector #(
  parameter int MAX_CHIPS = 8,
  parameter int TIMEOUT   = 64
) (
  input logic                   clk,
  input logic                   rst,
  power_table_collector_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_ACK, S_DONE, S_FAIL
  } state_t;

  localparam logic [3:0] MC      = 4'(MAX_CHIPS);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  table_q [16];
  logic [3:0]  table_d [16];
  logic [3:0]  chip_count_q, chip_count_d;
  logic [3:0]  exp_id_q, exp_id_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] ack_q, ack_d;

  logic [3:0]  f_hdr, f_pst, f_src, f_dst;
  logic [15:0] f_mark;
  logic        f_new, f_retry, f_ok;
  logic        do_clear, do_accept;

  assign f_hdr  = bus.frame_in[31:28];
  assign f_pst  = bus.frame_in[27:24];
  assign f_src  = bus.frame_in[23:20];
  assign f_dst  = bus.frame_in[19:16];
  assign f_mark = bus.frame_in[15:0];

  // A retry re-sends the most recently accepted chip.
  assign f_new   = (f_src == exp_id_q);
  assign f_retry = (f_src == 4'(exp_id_q - 4'd1))
                && (chip_count_q != 4'd0);
  assign f_ok    = (f_hdr == 4'hA)
                && (f_mark == 16'hBEAF)
                && (f_dst == 4'(f_src + 4'd1))
                && (f_new || f_retry);

  assign do_clear  = bus.start
                  && (state_q == S_IDLE
                   || state_q == S_DONE
                   || state_q == S_FAIL);
  assign do_accept = (state_q == S_COLLECT)
                  && bus.frame_vld && f_ok;

  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    chip_count_d = chip_count_q;
    exp_id_d     = exp_id_q;
    err_cnt_d    = err_cnt_q;
    timer_d      = timer_q;
    ack_d        = ack_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (do_clear) begin
          for (int i = 0; i < 16; i++) table_d[i] = 4'h0;
          chip_count_d = 4'd0;
          exp_id_d     = 4'd0;
          err_cnt_d    = 8'd0;
          timer_d      = 8'd0;
          state_d      = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (bus.frame_vld) begin
          timer_d = 8'd0;
          if (f_ok) begin
            table_d[f_src] = f_pst;
            if (f_new) begin
              chip_count_d = chip_count_q + 4'd1;
              exp_id_d     = exp_id_q + 4'd1;
            end
            ack_d   = {4'h5, f_pst, f_src, f_dst, 16'hBEAF};
            state_d = S_ACK;
          end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else if (timer_q == TO_LAST) begin
          state_d = (chip_count_q != 4'd0) ? S_DONE : S_FAIL;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_ACK: begin
        state_d = (chip_count_q == MC) ? S_DONE : S_COLLECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < 16; i++) table_q[i] <= 4'h0;
      chip_count_q <= 4'd0;
      exp_id_q     <= 4'd0;
      err_cnt_q    <= 8'd0;
      timer_q      <= 8'd0;
      ack_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      chip_count_q <= chip_count_d;
      exp_id_q     <= exp_id_d;
      err_cnt_q    <= err_cnt_d;
      timer_q      <= timer_d;
      ack_q        <= ack_d;
    end
  end

`ifdef PWR_SAT_FLAG_EN
  logic [15:0] sat_q, sat_d;

  // A retry with a lower p_state withdraws the saturation flag.
  always_comb begin
    sat_d = sat_q;
    if (do_clear) begin
      sat_d = 16'h0000;
    end else if (do_accept) begin
      if (f_pst == 4'hF) begin
        sat_d[f_src] = 1'b1;
      end else if (f_retry && (f_pst < table_q[f_src])) begin
        sat_d[f_src] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sat_q <= 16'h0000;
    else     sat_q <= sat_d;
  end

  assign bus.sat_mask = sat_q;
`else
  assign bus.sat_mask = 16'h0000;
`endif

  assign bus.rd_data    = table_q[bus.rd_addr];
  assign bus.ack_vld    = (state_q == S_ACK);
  assign bus.ack_data   = bus.ack_vld ? ack_q : 32'd0;
  assign bus.chip_count = chip_count_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.fail       = (state_q == S_FAIL);

endmodule

// File: tb/tb_power_table_collector.sv
// Directed self-checking bench for power_table_collector.
// Drives on negedge, samples on negedge; acks are counted by a negedge monitor.
module tb_power_table_collector;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   ack_cnt = 0;
  logic [31:0] last_ack = 32'd0;
  int   a0;

  always #5 clk = ~clk;

  power_table_collector_if bus ();

  power_table_collector #(
    .MAX_CHIPS (8),
    .TIMEOUT   (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (bus.ack_vld) begin
      ack_cnt  <= ack_cnt + 1;
      last_ack <= bus.ack_data;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(
    input logic [3:0] hdr, input logic [3:0] p,
    input logic [3:0] s, input logic [3:0] d,
    input logic [15:0] m);
    return {hdr, p, s, d, m};
  endfunction

  task automatic send(input logic [31:0] f);
    @(negedge clk);
    bus.frame_vld = 1'b1;
    bus.frame_in  = f;
    @(negedge clk);
    bus.frame_vld = 1'b0;
    bus.frame_in  = 32'd0;
    @(negedge clk);
  endtask

  task automatic good(input logic [3:0] p, input logic [3:0] s);
    send(mk(4'hA, p, s, 4'(s + 4'd1), 16'hBEAF));
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [3:0] v);
    bus.rd_addr = a;
    #1;
    v = bus.rd_data;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && !bus.done && !bus.fail; i++)
      @(negedge clk);
  endtask

  initial begin
    logic [3:0] v;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.frame_vld = 1'b0;
    bus.frame_in  = 32'd0;
    bus.rd_addr   = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cnt",  32'(bus.chip_count), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_fail", 32'(bus.fail), 32'd0);
    chk("rst_ack",  bus.ack_data, 32'd0);

    // Full collection of 8 chips.
    a0 = ack_cnt;
    do_start();
    for (int i = 0; i < 8; i++) good(4'd1, 4'(i));
    chk("full_acks", 32'(ack_cnt - a0), 32'd8);
    chk("full_cnt",  32'(bus.chip_count), 32'd8);
    chk("full_done", 32'(bus.done), 32'd1);
    chk("full_last", last_ack, 32'h5178BEAF);
    rd(4'd3, v);
    chk("full_rd3", 32'(v), 32'd1);
    chk("idle_ackd", bus.ack_data, 32'd0);

    // Rejected frames, then a new frame and its retry.
    do_start();
    a0 = ack_cnt;
    send(mk(4'hA, 4'd1, 4'd0, 4'd1, 16'hBEAE));
    send(mk(4'hA, 4'd1, 4'd0, 4'd2, 16'hBEAF));
    chk("bad_err",  32'(bus.err_cnt), 32'd2);
    chk("bad_ack",  32'(ack_cnt - a0), 32'd0);
    chk("bad_cnt",  32'(bus.chip_count), 32'd0);
    good(4'd2, 4'd0);
    good(4'd5, 4'd0);
    chk("rty_cnt",  32'(bus.chip_count), 32'd1);
    rd(4'd0, v);
    chk("rty_rd0",  32'(v), 32'd5);
    chk("rty_acks", 32'(ack_cnt - a0), 32'd2);
    chk("rty_last", last_ack, 32'h5501BEAF);
    send(mk(4'hB, 4'd1, 4'd1, 4'd2, 16'hBEAF));
    good(4'd1, 4'd3);
    chk("hdr_src_err", 32'(bus.err_cnt), 32'd4);
    wait_done(100);
    chk("to_done", 32'(bus.done), 32'd1);
    chk("to_nofail", 32'(bus.fail), 32'd0);
    good(4'd1, 4'd1);
    chk("done_noerr", 32'(bus.err_cnt), 32'd4);

    // Empty collection times out after exactly 64 idle cycles.
    a0 = ack_cnt;
    do_start();
    repeat (63) @(negedge clk);
    chk("to_early", 32'(bus.fail), 32'd0);
    @(negedge clk);
    chk("to_fail",  32'(bus.fail), 32'd1);
    chk("to_cnt",   32'(bus.chip_count), 32'd0);
    chk("to_noack", 32'(ack_cnt - a0), 32'd0);

    // Reset mid-collection.
    do_start();
    for (int i = 0; i < 3; i++) good(4'd7, 4'(i));
    send(mk(4'hA, 4'd1, 4'd9, 4'd1, 16'hBEAF));
    chk("pre_rst_err", 32'(bus.err_cnt), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_cnt",  32'(bus.chip_count), 32'd0);
    chk("mr_err",  32'(bus.err_cnt), 32'd0);
    chk("mr_done", 32'(bus.done), 32'd0);
    chk("mr_fail", 32'(bus.fail), 32'd0);
    chk("mr_avld", 32'(bus.ack_vld), 32'd0);
    chk("mr_sat",  32'(bus.sat_mask), 32'd0);
    rd(4'd1, v);
    chk("mr_rd1",  32'(v), 32'd0);

    // Restart at chip 0; saturated p_state then a lower retry.
    a0 = ack_cnt;
    do_start();
    good(4'hF, 4'd0);
    chk("rs_cnt",  32'(bus.chip_count), 32'd1);
    chk("rs_ack",  32'(ack_cnt - a0), 32'd1);
    rd(4'd0, v);
    chk("rs_rd0",  32'(v), 32'd15);
`ifdef PWR_SAT_FLAG_EN
    chk("sat_set", 32'(bus.sat_mask), 32'h0001);
`else
    chk("sat_set", 32'(bus.sat_mask), 32'h0000);
`endif
    good(4'd3, 4'd0);
    chk("sat_clr", 32'(bus.sat_mask), 32'h0000);
    chk("rs2_cnt", 32'(bus.chip_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
